unidade_controle_exp7: RTL and testbench
========================================

Name: unidade_controle_exp7

Overview:
- Moore FSM that sequences the multi-round memory-game datapath: sequence memory, address counter (C), round-limit counter (L), move register (R) and comparator.
- Round k requires the player to repeat memory positions 0..k. Each move has a cycle-count timeout enforced by an internal counter.
- Sits beside the datapath in the top-level game circuit. Drives the counter and register controls; reports result and debug state.

Parameters:
- TIMEOUT, default 5000: cycles allowed in espera_jogada before a timeout; must be ≥2.
- TW, default 13: width of the internal timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- iniciar  in  1  start / restart request.
- jogada  in  1  one-cycle pulse: player move present.
- igual  in  1  comparator: registered move equals memory data.
- enderecoIgualLimite  in  1  address counter C equals round counter L.
- fimL  in  1  round counter L at its last value.
- zeraC  out  1  clear address counter.
- contaC  out  1  increment address counter.
- zeraL  out  1  clear round counter.
- contaL  out  1  increment round counter.
- zeraR  out  1  clear move register.
- registraR  out  1  load move register.
- acertou  out  1  game won.
- errou  out  1  game lost (wrong move or timeout).
- timeout  out  1  game lost by timeout.
- pronto  out  1  game finished.
- db_estado  out  4  debug state code.

Behaviour:
- Reset: a synchronous reset forces state inicial and clears the timeout counter on the next rising edge. Outputs are Moore-only, so the state dictates their values after that edge.
- Reset values: zeraC=zeraL=zeraR=1; all other control and status outputs 0; db_estado=0x0.
- reset overrides every other input and is honoured in any state, including mid-round.
- States, db_estado codes and transitions:
  - inicial 0x0: iniciar → preparacao; otherwise stay.
  - preparacao 0x1: → inicio_rodada.
  - inicio_rodada 0x2: → espera_jogada.
  - espera_jogada 0x3: jogada → registra. Otherwise, if tcount==TIMEOUT-1 → fim_timeout. Otherwise stay.
  - registra 0x4: → comparacao.
  - comparacao 0x5, evaluated in priority order:
    - ~igual → fim_errou.
    - igual & ~enderecoIgualLimite → proximo.
    - igual & enderecoIgualLimite & ~fimL → proxima_rodada.
    - igual & enderecoIgualLimite & fimL → fim_acertou.
  - proximo 0x6: → espera_jogada.
  - proxima_rodada 0x7: → inicio_rodada.
  - fim_acertou 0xA, fim_errou 0xE, fim_timeout 0xD: iniciar → preparacao; otherwise hold.
  - Any illegal encoding → inicial; db_estado=0xF while in it.
- Output decode:
  - zeraC, zeraR: inicial, preparacao, inicio_rodada.
  - zeraL: inicial, preparacao.
  - registraR: registra.
  - contaC: proximo.
  - contaL: proxima_rodada.
  - pronto: all three end states.
  - acertou: fim_acertou.
  - errou: fim_errou and fim_timeout.
  - timeout: fim_timeout.
- Timeout counter tcount (TW bits):
  - Increments each cycle the FSM is in espera_jogada; cleared to 0 in every other state.
  - Therefore it is 0 on the first cycle of each espera_jogada visit. The timeout fires after exactly TIMEOUT consecutive cycles without jogada.
  - jogada on the same cycle as tcount==TIMEOUT-1: jogada wins and the FSM goes to registra.
  - tcount never wraps; it is bounded by the timeout exit.
- jogada outside espera_jogada is ignored. iniciar outside inicial and the end states is ignored.
- Latency: jogada sampled → registraR next cycle → comparison result acted on the cycle after.

Test Plan:
- Reset mid-game: with TIMEOUT=8, assert reset while in comparacao. Next edge: db_estado=0x0, zeraC=zeraL=zeraR=1, all other outputs 0.
- Full win, 2-round game: iniciar=1, then moves with igual=1. Drive enderecoIgualLimite=1 on the round-0 move, then 0/1 on round 1's two moves, with fimL=1 in round 1. Require visit sequence 0,1,2,3,4,5,7,2,3,4,5,6,3,4,5,A, and contaL high exactly 1 cycle. Final acertou=1, pronto=1.
- Wrong move: in round 0, igual=0 at comparacao → db_estado=0xE, errou=1, timeout=0, pronto=1.
- Timeout: TIMEOUT=8, no jogada for 8 cycles in espera_jogada → fim_timeout (0xD) on the 9th edge. errou=1, timeout=1, pronto=1, acertou=0.
- Timeout boundary: jogada asserted on the 8th cycle (tcount=7) → registra (0x4), no timeout. Counter restarts at 0 on the next espera_jogada visit.
- Restart from end state: in fim_errou assert iniciar → preparacao. Counters are zeroed (zeraC=zeraL=1 for one cycle) and errou drops.

Source files
------------

// File: rtl/unidade_controle_exp7_if.sv
// Control/status bundle between the memory-game control unit and its
// datapath / player inputs.
//   master : the control unit (samples player and datapath flags, drives
//            counter/register controls, result flags and the debug code)
//   slave  : the datapath and player side
interface unidade_controle_exp7_if;
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       enderecoIgualLimite;
    logic       fimL;
    logic       zeraC;
    logic       contaC;
    logic       zeraL;
    logic       contaL;
    logic       zeraR;
    logic       registraR;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic       pronto;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, jogada, igual, enderecoIgualLimite, fimL,
        output zeraC, contaC, zeraL, contaL, zeraR, registraR,
        output acertou, errou, timeout, pronto, db_estado
    );

    modport slave (
        output iniciar, jogada, igual, enderecoIgualLimite, fimL,
        input  zeraC, contaC, zeraL, contaL, zeraR, registraR,
        input  acertou, errou, timeout, pronto, db_estado
    );
endinterface

// File: rtl/unidade_controle_exp7.sv
// Moore control unit for the multi-round memory game. Round k asks the
// player to repeat positions 0..k; each move must arrive within TIMEOUT
// cycles of entering espera_jogada.
// Ports:
//   clock  : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : master side of unidade_controle_exp7_if (player inputs,
//            datapath flags, counter/register controls, result, debug)
//
// state          | code | meaning
// inicial        | 0x0  | idle, datapath held cleared, waits for iniciar
// preparacao     | 0x1  | clear C, L and R before a new game
// inicio_rodada  | 0x2  | clear C and R at the start of a round
// espera_jogada  | 0x3  | wait for a move, timeout counter running
// registra       | 0x4  | load the move into R
// comparacao     | 0x5  | act on comparator and counter flags
// proximo        | 0x6  | advance C to the next position of the round
// proxima_rodada | 0x7  | advance L to the next round
// fim_acertou    | 0xA  | game won
// fim_timeout    | 0xD  | game lost by timeout
// fim_errou      | 0xE  | game lost by wrong move
// (illegal)      | 0xF  | debug code only; recovers to inicial
module unidade_controle_exp7 #(
    parameter int TIMEOUT = 5000,
    parameter int TW      = 13
) (
    input  logic                    clock,
    input  logic                    reset,
    unidade_controle_exp7_if.master bus
);

    typedef enum logic [3:0] {
        inicial        = 4'h0,
        preparacao     = 4'h1,
        inicio_rodada  = 4'h2,
        espera_jogada  = 4'h3,
        registra       = 4'h4,
        comparacao     = 4'h5,
        proximo        = 4'h6,
        proxima_rodada = 4'h7,
        fim_acertou    = 4'hA,
        fim_timeout    = 4'hD,
        fim_errou      = 4'hE
    } estado_t;

    estado_t       estado;
    estado_t       proximo_estado;
    logic [TW-1:0] tcount;
    logic          expirou;

    logic zerac_w, contac_w, zeral_w, contal_w, zerar_w, registrar_w;
    logic acertou_w, errou_w, timeout_w, pronto_w;
    logic [3:0] db_w;

    assign expirou = (tcount == TW'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) estado <= inicial;
        else       estado <= proximo_estado;
    end

    // Counts only while staying in espera_jogada, so it is 0 on the first
    // cycle of every visit and never passes TIMEOUT-1.
    always_ff @(posedge clock) begin
        if (reset)
            tcount <= '0;
        else if (estado == espera_jogada && proximo_estado == espera_jogada)
            tcount <= tcount + TW'(1);
        else
            tcount <= '0;
    end

    always_comb begin
        proximo_estado = estado;
        case (estado)
            inicial:        if (bus.iniciar) proximo_estado = preparacao;
            preparacao:     proximo_estado = inicio_rodada;
            inicio_rodada:  proximo_estado = espera_jogada;
            espera_jogada: begin
                // a move on the last allowed cycle still counts
                if (bus.jogada)   proximo_estado = registra;
                else if (expirou) proximo_estado = fim_timeout;
            end
            registra:       proximo_estado = comparacao;
            comparacao: begin
                if (!bus.igual)                    proximo_estado = fim_errou;
                else if (!bus.enderecoIgualLimite) proximo_estado = proximo;
                else if (!bus.fimL)                proximo_estado = proxima_rodada;
                else                               proximo_estado = fim_acertou;
            end
            proximo:        proximo_estado = espera_jogada;
            proxima_rodada: proximo_estado = inicio_rodada;
            fim_acertou, fim_errou, fim_timeout:
                            if (bus.iniciar) proximo_estado = preparacao;
            default:        proximo_estado = inicial;
        endcase
    end

    always_comb begin
        zerac_w     = 1'b0;
        contac_w    = 1'b0;
        zeral_w     = 1'b0;
        contal_w    = 1'b0;
        zerar_w     = 1'b0;
        registrar_w = 1'b0;
        acertou_w   = 1'b0;
        errou_w     = 1'b0;
        timeout_w   = 1'b0;
        pronto_w    = 1'b0;
        db_w        = 4'hF;
        case (estado)
            inicial:        begin db_w = 4'h0; zerac_w = 1'b1; zeral_w = 1'b1; zerar_w = 1'b1; end
            preparacao:     begin db_w = 4'h1; zerac_w = 1'b1; zeral_w = 1'b1; zerar_w = 1'b1; end
            inicio_rodada:  begin db_w = 4'h2; zerac_w = 1'b1; zerar_w = 1'b1; end
            espera_jogada:  db_w = 4'h3;
            registra:       begin db_w = 4'h4; registrar_w = 1'b1; end
            comparacao:     db_w = 4'h5;
            proximo:        begin db_w = 4'h6; contac_w = 1'b1; end
            proxima_rodada: begin db_w = 4'h7; contal_w = 1'b1; end
            fim_acertou:    begin db_w = 4'hA; acertou_w = 1'b1; pronto_w = 1'b1; end
            fim_timeout:    begin db_w = 4'hD; errou_w = 1'b1; timeout_w = 1'b1; pronto_w = 1'b1; end
            fim_errou:      begin db_w = 4'hE; errou_w = 1'b1; pronto_w = 1'b1; end
            default:        db_w = 4'hF;
        endcase
    end

    assign bus.zeraC     = zerac_w;
    assign bus.contaC    = contac_w;
    assign bus.zeraL     = zeral_w;
    assign bus.contaL    = contal_w;
    assign bus.zeraR     = zerar_w;
    assign bus.registraR = registrar_w;
    assign bus.acertou   = acertou_w;
    assign bus.errou     = errou_w;
    assign bus.timeout   = timeout_w;
    assign bus.pronto    = pronto_w;
    assign bus.db_estado = db_w;

endmodule

// File: tb/tb_unidade_controle_exp7.sv
// Bench for unidade_controle_exp7. A game-level model plays rounds and
// moves with random response delays and wrong moves, and queues the debug
// code expected after every clock edge; a monitor pops and compares the
// code and all control/status outputs one step after each rising edge.
module tb_unidade_controle_exp7;
    localparam int TIMEOUT = 8;
    localparam int TW      = 4;

    localparam logic [3:0] S_INI   = 4'h0;
    localparam logic [3:0] S_PREP  = 4'h1;
    localparam logic [3:0] S_INIRD = 4'h2;
    localparam logic [3:0] S_ESP   = 4'h3;
    localparam logic [3:0] S_REG   = 4'h4;
    localparam logic [3:0] S_CMP   = 4'h5;
    localparam logic [3:0] S_PROX  = 4'h6;
    localparam logic [3:0] S_PRXR  = 4'h7;
    localparam logic [3:0] S_WIN   = 4'hA;
    localparam logic [3:0] S_TO    = 4'hD;
    localparam logic [3:0] S_ERR   = 4'hE;

    logic clock = 1'b0;
    logic reset = 1'b1;
    unidade_controle_exp7_if bus();

    unidade_controle_exp7 #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [3:0] expq[$];
    logic [3:0] cur_state;
    int n_tests = 0;
    int n_fail  = 0;

    // {zeraC, contaC, zeraL, contaL, zeraR, registraR, acertou, errou, timeout, pronto}
    function automatic logic [9:0] outs_of(input logic [3:0] s);
        logic zc, cc, zl, cl, zr, rr, ac, er, to, pr;
        zc = (s == S_INI) || (s == S_PREP) || (s == S_INIRD);
        zr = zc;
        zl = (s == S_INI) || (s == S_PREP);
        cc = (s == S_PROX);
        cl = (s == S_PRXR);
        rr = (s == S_REG);
        ac = (s == S_WIN);
        er = (s == S_ERR) || (s == S_TO);
        to = (s == S_TO);
        pr = (s == S_WIN) || (s == S_ERR) || (s == S_TO);
        return {zc, cc, zl, cl, zr, rr, ac, er, to, pr};
    endfunction

    initial begin
        logic [3:0] e;
        logic [9:0] got;
        forever begin
            @(posedge clock);
            #1;
            if (expq.size() > 0) begin
                e   = expq.pop_front();
                got = {bus.zeraC, bus.contaC, bus.zeraL, bus.contaL, bus.zeraR,
                       bus.registraR, bus.acertou, bus.errou, bus.timeout, bus.pronto};
                n_tests++;
                if (bus.db_estado !== e) begin
                    n_fail++;
                    $display("FAIL db_estado @%0t: got %h, expected %h", $time, bus.db_estado, e);
                end
                n_tests++;
                if (got !== outs_of(e)) begin
                    n_fail++;
                    $display("FAIL outputs (state %h) @%0t: got %b, expected %b", e, $time, got, outs_of(e));
                end
            end
        end
    end

    task automatic step(input logic ini, input logic jog, input logic ig,
                        input logic eil, input logic fl, input logic rst,
                        input logic [3:0] exp_state);
        @(negedge clock);
        reset                   = rst;
        bus.iniciar             = ini;
        bus.jogada              = jog;
        bus.igual               = ig;
        bus.enderecoIgualLimite = eil;
        bus.fimL                = fl;
        expq.push_back(exp_state);
        cur_state = exp_state;
    endtask

    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 5)      return int'($urandom_range(0, 2));
        else if (r < 7) return TIMEOUT - 1;
        else if (r < 8) return TIMEOUT + int'($urandom_range(0, 2));
        else            return int'($urandom_range(0, TIMEOUT - 1));
    endfunction

    // One game: fixed_delay < 0 selects random delays; wrong_move is the
    // global move index answered wrongly (-1 for none).
    task automatic play_game(input int nrounds, input int fixed_delay,
                             input int wrong_move, input bit rst_cmp);
        int  mv;
        int  d;
        bit  bad;
        logic eil, fl, ig;
        mv = 0;
        step(1'b1, 1'(($urandom) % 2), 1'b0, 1'b0, 1'b0, 1'b0, S_PREP);
        step(1'(($urandom) % 2), 1'(($urandom) % 2), 1'b0, 1'b0, 1'b0, 1'b0, S_INIRD);
        step(1'(($urandom) % 2), 1'(($urandom) % 2), 1'b0, 1'b0, 1'b0, 1'b0, S_ESP);
        for (int k = 0; k < nrounds; k++) begin
            for (int j = 0; j <= k; j++) begin
                d   = (fixed_delay >= 0) ? fixed_delay : pick_delay();
                bad = (mv == wrong_move);
                eil = (j == k);
                fl  = (k == nrounds - 1);
                ig  = !bad;
                for (int t = 0; t < d; t++) begin
                    if (t == TIMEOUT - 1) begin
                        step(1'b0, 1'b0, ig, eil, fl, 1'b0, S_TO);
                        return;
                    end
                    step(1'b0, 1'b0, ig, eil, fl, 1'b0, S_ESP);
                end
                step(1'(($urandom) % 2), 1'b1, ig, eil, fl, 1'b0, S_REG);
                step(1'(($urandom) % 2), 1'(($urandom) % 2), ig, eil, fl, 1'b0, S_CMP);
                if (rst_cmp) begin
                    step(1'b1, 1'b1, ig, eil, fl, 1'b1, S_INI);
                    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_INI);
                    return;
                end
                if (bad) begin
                    step(1'b0, 1'b0, ig, eil, fl, 1'b0, S_ERR);
                    return;
                end else if (!eil) begin
                    step(1'b0, 1'(($urandom) % 2), ig, eil, fl, 1'b0, S_PROX);
                    step(1'(($urandom) % 2), 1'(($urandom) % 2), ig, eil, fl, 1'b0, S_ESP);
                end else if (!fl) begin
                    step(1'b0, 1'(($urandom) % 2), ig, eil, fl, 1'b0, S_PRXR);
                    step(1'(($urandom) % 2), 1'(($urandom) % 2), ig, eil, fl, 1'b0, S_INIRD);
                    step(1'(($urandom) % 2), 1'(($urandom) % 2), ig, eil, fl, 1'b0, S_ESP);
                end else begin
                    step(1'b0, 1'b0, ig, eil, fl, 1'b0, S_WIN);
                    return;
                end
                mv++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'(($urandom) % 2), 1'(($urandom) % 2), 1'(($urandom) % 2),
                 1'(($urandom) % 2), 1'b0, cur_state);
    endtask

    initial begin
        bus.iniciar             = 1'b0;
        bus.jogada              = 1'b0;
        bus.igual               = 1'b0;
        bus.enderecoIgualLimite = 1'b0;
        bus.fimL                = 1'b0;
        cur_state               = S_INI;

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_INI);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, S_INI);
        idle(3);

        play_game(2, 0, -1, 1'b0);            // full 2-round win
        idle(2);
        play_game(1, 0, 0, 1'b0);             // wrong move in round 0, restart from win
        idle(2);
        play_game(1, TIMEOUT, -1, 1'b0);      // timeout, restart from fim_errou
        idle(2);
        play_game(3, TIMEOUT - 1, -1, 1'b0);  // every move on the last allowed cycle
        idle(1);
        play_game(2, 0, -1, 1'b1);            // reset while in comparacao
        idle(1);

        for (int g = 0; g < 40; g++) begin
            play_game(int'($urandom_range(1, 4)), -1, int'($urandom_range(0, 12)) - 2,
                      ($urandom_range(0, 9) == 0));
            idle(int'($urandom_range(0, 3)));
        end

        @(negedge clock);
        @(posedge clock);
        #2;
        n_tests++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected states left unchecked, expected 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
